sid_clock_reset_gen: RTL

- Consumes the 50.25 MHz PLL output clock and its `locked` flag. Produces the SID core's clock-enable tick and its chip reset.
- Qualifies the asynchronous lock signal and waits for the PLL to settle.
- Generates a fractional-rate enable from a phase accumulator (default ≈985248 Hz, PAL phi2).
- Holds the SID in reset for a minimum number of phi2 ticks before releasing it.
- Sits between the PLL and the top-level SID voice/filter logic.

---
 rtl/sid_clock_reset_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sid_clock_reset_gen.sv
// Clock-enable and reset generator for the SID core: qualifies PLL lock, derives
// the phi2 tick from a phase accumulator and holds the core in reset for a few ticks.
module sid_clock_reset_gen #(
  parameter int unsigned ACC_WIDTH   = 24,
  parameter int unsigned INCREMENT   = 328949,
  parameter int unsigned LOCK_WAIT   = 65536,
  parameter int unsigned RESET_TICKS = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic locked,
  output logic sid_tick,
  output logic sid_reset,
  output logic ready,
  output logic lock_lost
);

  localparam int unsigned SW = $clog2(LOCK_WAIT) + 1;
  localparam int unsigned TW = $clog2(RESET_TICKS) + 1;
  localparam logic [SW-1:0]      SETTLE_LAST = SW'(LOCK_WAIT - 1);
  localparam logic [TW-1:0]      TICK_LAST   = TW'(RESET_TICKS - 1);
  localparam logic [ACC_WIDTH:0] STEP        = (ACC_WIDTH+1)'(INCREMENT);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    HOLD,
    RUN
  } state_t;

  state_t               state, state_n;
  logic                 lock_m, lock_s;
  logic [SW-1:0]        settle_cnt, settle_n;
  logic [TW-1:0]        tick_cnt, tick_cnt_n;
  logic [ACC_WIDTH-1:0] acc, acc_n;
  logic [ACC_WIDTH:0]   sum;
  logic                 tick_n, sid_reset_n, ready_n, lock_lost_n;

  // Carry out of the accumulator is the tick; wrap-around is intended.
  assign sum = {1'b0, acc} + STEP;

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_m     <= 1'b0;
      lock_s     <= 1'b0;
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      tick_cnt   <= '0;
      acc        <= '0;
      sid_tick   <= 1'b0;
      sid_reset  <= 1'b1;
      ready      <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      lock_m     <= locked;
      lock_s     <= lock_m;
      state      <= state_n;
      settle_cnt <= settle_n;
      tick_cnt   <= tick_cnt_n;
      acc        <= acc_n;
      sid_tick   <= tick_n;
      sid_reset  <= sid_reset_n;
      ready      <= ready_n;
      lock_lost  <= lock_lost_n;
    end
  end

  always_comb begin
    state_n     = state;
    settle_n    = settle_cnt;
    tick_cnt_n  = tick_cnt;
    acc_n       = acc;
    tick_n      = 1'b0;
    sid_reset_n = 1'b1;
    ready_n     = 1'b0;
    lock_lost_n = lock_lost;
    case (state)
      WAIT_LOCK: begin
        settle_n   = '0;
        tick_cnt_n = '0;
        acc_n      = '0;
        if (lock_s) state_n = SETTLE;
      end
      SETTLE: begin
        if (!lock_s) begin
          state_n  = WAIT_LOCK;
          settle_n = '0;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_n    = HOLD;
          settle_n   = '0;
          tick_cnt_n = '0;
          acc_n      = '0;
        end else begin
          settle_n = settle_cnt + 1'b1;
        end
      end
      HOLD, RUN: begin
        // Lock loss wins over any tick or count completion in the same cycle.
        if (!lock_s) begin
          state_n    = WAIT_LOCK;
          settle_n   = '0;
          tick_cnt_n = '0;
          acc_n      = '0;
          if (state == RUN) lock_lost_n = 1'b1;
        end else begin
          acc_n  = sum[ACC_WIDTH-1:0];
          tick_n = sum[ACC_WIDTH];
          if (state == RUN) begin
            sid_reset_n = 1'b0;
            ready_n     = 1'b1;
          end else if (sum[ACC_WIDTH]) begin
            if (tick_cnt == TICK_LAST) begin
              state_n     = RUN;
              sid_reset_n = 1'b0;
              ready_n     = 1'b1;
            end else begin
              tick_cnt_n = tick_cnt + 1'b1;
            end
          end
        end
      end
      default: state_n = WAIT_LOCK;
    endcase
  end

endmodule
